// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2
  } if_state_e;

  typedef enum logic [1:0] {
    PC_KEEP   = 2'd0,
    PC_INC    = 2'd1,
    PC_TARGET = 2'd2,
    PC_PEND   = 2'd3
  } pc_sel_e;

  localparam logic [31:0] IF_NOP           = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/if_fetch_fsm.sv
// Fetch control FSM: owns the RUN/HOLD/DROP state, the pending redirect target
// and the one-entry hold buffer; tells the top how to update PC and IF/ID.
module if_fetch_fsm
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        bubble,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_tgt,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output if_state_e   state,
  output pc_sel_e     pc_sel,
  output logic [31:0] pend_tgt,
  output logic        ifid_load,
  output logic        ifid_clear,
  output logic [31:0] load_instr
);

  if_state_e   state_q, state_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] hold_q, hold_d;

  // Next-state, PC-select and IF/ID strobe decode; redirect outranks bubble.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    hold_d     = hold_q;
    pc_sel     = PC_KEEP;
    ifid_load  = 1'b0;
    ifid_clear = 1'b0;
    load_instr = IF_NOP;
    case (state_q)
      RUN: begin
        if (redirect_valid) begin
          ifid_clear = 1'b1;
          if (imem_ready) begin
            pc_sel = PC_TARGET;
          end else begin
            pend_d  = redirect_tgt;
            state_d = DROP;
          end
        end else if (imem_ready && bubble) begin
          hold_d  = imem_rdata;
          state_d = HOLD;
        end else if (imem_ready) begin
          ifid_load  = 1'b1;
          load_instr = imem_rdata;
          pc_sel     = PC_INC;
        end else if (!bubble) begin
          // A wait cycle with ID free sends a bubble into ID.
          ifid_clear = 1'b1;
        end else begin
          ifid_clear = 1'b0;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          hold_d     = IF_NOP;
          pc_sel     = PC_TARGET;
          ifid_clear = 1'b1;
          state_d    = RUN;
        end else if (!bubble) begin
          ifid_load  = 1'b1;
          load_instr = hold_q;
          hold_d     = IF_NOP;
          pc_sel     = PC_INC;
          state_d    = RUN;
        end else begin
          state_d = HOLD;
        end
      end
      DROP: begin
        ifid_clear = 1'b1;
        if (redirect_valid) begin
          pend_d = redirect_tgt;
        end else begin
          pend_d = pend_q;
        end
        if (imem_ready) begin
          pc_sel  = redirect_valid ? PC_TARGET : PC_PEND;
          pend_d  = 32'h0000_0000;
          state_d = RUN;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        ifid_clear = 1'b1;
        state_d    = RUN;
      end
    endcase
  end

  // State, pending target and hold buffer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pend_q  <= 32'h0000_0000;
      hold_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      hold_q  <= hold_d;
    end
  end

  assign state    = state_q;
  assign pend_tgt = pend_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem request and the IF/ID pipeline register.
// Optional `IF_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bubble,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  if_stage_if.master  imem,
  output logic [31:0] IF_ID_PC_Plus4,
  output logic [31:0] IF_ID_Instruction,
  output logic        IF_ID_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  if_state_e   state;
  pc_sel_e     pc_sel;
  logic [31:0] pend_tgt;
  logic        ifid_load;
  logic        ifid_clear;
  logic [31:0] load_instr;
  logic [31:0] redirect_tgt;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pp4_q, pp4_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  assign redirect_tgt = align_pc(redirect_pc);

  if_fetch_fsm u_fsm (
    .clk            (clk),
    .reset          (reset),
    .bubble         (bubble),
    .redirect_valid (redirect_valid),
    .redirect_tgt   (redirect_tgt),
    .imem_ready     (imem.imem_ready),
    .imem_rdata     (imem.imem_rdata),
    .state          (state),
    .pc_sel         (pc_sel),
    .pend_tgt       (pend_tgt),
    .ifid_load      (ifid_load),
    .ifid_clear     (ifid_clear),
    .load_instr     (load_instr)
  );

  // Next PC and next IF/ID contents.
  always_comb begin
    case (pc_sel)
      PC_KEEP:   pc_d = pc_q;
      PC_INC:    pc_d = pc_plus4(pc_q);
      PC_TARGET: pc_d = redirect_tgt;
      PC_PEND:   pc_d = pend_tgt;
      default:   pc_d = pc_q;
    endcase
    if (ifid_load) begin
      pp4_d   = pc_plus4(pc_q);
      instr_d = load_instr;
      valid_d = 1'b1;
    end else if (ifid_clear) begin
      pp4_d   = 32'h0000_0000;
      instr_d = IF_NOP;
      valid_d = 1'b0;
    end else begin
      pp4_d   = pp4_q;
      instr_d = instr_q;
      valid_d = valid_q;
    end
  end

  // PC and IF/ID registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      pp4_q   <= 32'h0000_0000;
      instr_q <= IF_NOP;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pp4_q   <= pp4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign imem.imem_req     = (state != HOLD);
  assign imem.imem_addr    = pc_q;
  assign IF_ID_PC_Plus4    = pp4_q;
  assign IF_ID_Instruction = instr_q;
  assign IF_ID_valid       = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stall_q, stall_d;

  // Wrapping performance counter increments.
  always_comb begin
    if (ifid_load) begin
      fetched_d = fetched_q + 32'd1;
    end else begin
      fetched_d = fetched_q;
    end
    if (bubble || (state != RUN)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= 32'h0000_0000;
      stall_q   <= 32'h0000_0000;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus random traffic
// against a transaction-level fetch model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        bubble;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] IF_ID_PC_Plus4;
  logic [31:0] IF_ID_Instruction;
  logic        IF_ID_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  if_stage_if imem ();

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk               (clk),
    .reset             (reset),
    .bubble            (bubble),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .imem              (imem),
    .IF_ID_PC_Plus4    (IF_ID_PC_Plus4),
    .IF_ID_Instruction (IF_ID_Instruction),
    .IF_ID_valid       (IF_ID_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched      (perf_fetched),
    .perf_stall        (perf_stall)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // stimulus controls for the next cycle
  bit          c_reset, c_bubble, c_rv, data_xor, allow_stray;
  logic [31:0] c_rpc;
  int          lat_mode;

  // memory responder
  bit mem_busy = 1'b0;
  int mem_cnt  = 0;

  // reference model: the fetch address, whether a fetched word is parked,
  // whether the outstanding fetch is stale, and what ID currently sees
  bit          m_known = 1'b0;
  logic [31:0] m_pc, m_pend, m_buf;
  bit          m_parked, m_stale;
  logic [31:0] m_pp4, m_ins;
  bit          m_val;

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    if (m_known) begin
      vectors++;
      if (imem.imem_req !== !m_parked || imem.imem_addr !== m_pc ||
          IF_ID_valid !== m_val || IF_ID_Instruction !== m_ins || IF_ID_PC_Plus4 !== m_pp4) begin
        miscompares++;
        $display("FAIL cycle t=%0t: got req=%b addr=%h v=%b ins=%h pp4=%h expected req=%b addr=%h v=%b ins=%h pp4=%h",
                 $time, imem.imem_req, imem.imem_addr, IF_ID_valid, IF_ID_Instruction, IF_ID_PC_Plus4,
                 !m_parked, m_pc, m_val, m_ins, m_pp4);
      end
    end
  endtask

  task automatic send_to_id(input bit v, input logic [31:0] pc, input logic [31:0] word);
    m_val = v;
    m_ins = v ? word : 32'h0000_0000;
    m_pp4 = v ? pc + 32'd4 : 32'h0000_0000;
  endtask

  task automatic model_step(input bit rst, input bit bub, input bit rv, input logic [31:0] rpc,
                            input bit rdy, input logic [31:0] rdata);
    logic [31:0] tgt;
    bit          got;
    tgt = {rpc[31:2], 2'b00};
    got = rdy && !m_parked;
    if (rst) begin
      m_known = 1'b1; m_pc = 32'h0000_0000; m_pend = 32'h0000_0000; m_buf = 32'h0000_0000;
      m_parked = 1'b0; m_stale = 1'b0;
      send_to_id(1'b0, 32'h0, 32'h0);
    end else if (m_parked) begin
      if (rv) begin
        m_parked = 1'b0; m_pc = tgt; send_to_id(1'b0, 32'h0, 32'h0);
      end else if (!bub) begin
        m_parked = 1'b0; send_to_id(1'b1, m_pc, m_buf); m_pc = m_pc + 32'd4;
      end
    end else if (m_stale) begin
      send_to_id(1'b0, 32'h0, 32'h0);
      if (rv) m_pend = tgt;
      if (got) begin
        m_pc = m_pend; m_stale = 1'b0;
      end
    end else if (rv) begin
      send_to_id(1'b0, 32'h0, 32'h0);
      if (got) m_pc = tgt;
      else begin
        m_pend = tgt; m_stale = 1'b1;
      end
    end else if (got && bub) begin
      m_buf = rdata; m_parked = 1'b1;
    end else if (got) begin
      send_to_id(1'b1, m_pc, rdata); m_pc = m_pc + 32'd4;
    end else if (!bub) begin
      send_to_id(1'b0, 32'h0, 32'h0);
    end
  endtask

  // One clock: check outputs, drive inputs and memory response at negedge, advance model.
  task automatic tick();
    bit          rdy;
    logic [31:0] rd;
    @(negedge clk);
    compare_outputs();
    rdy = 1'b0;
    rd  = $urandom;
    if (c_reset) begin
      mem_busy = 1'b0;
    end else if (imem.imem_req === 1'b1) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
      end
      if (mem_cnt == 0) begin
        rdy = 1'b1; mem_busy = 1'b0;
        rd  = data_xor ? (imem.imem_addr ^ 32'h5A5A_0000) : imem.imem_addr;
      end else begin
        mem_cnt--;
      end
    end else if (allow_stray) begin
      rdy = ($urandom_range(0, 3) == 0);
    end
    reset = c_reset; bubble = c_bubble; redirect_valid = c_rv; redirect_pc = c_rpc;
    imem.imem_ready = rdy; imem.imem_rdata = rd;
    model_step(c_reset, c_bubble, c_rv, c_rpc, rdy, rd);
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] a, p, ins;
    bit          found;
    reset = 1'b1; bubble = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem.imem_ready = 1'b0; imem.imem_rdata = 32'h0;
    c_reset = 1'b1; c_bubble = 1'b0; c_rv = 1'b0; c_rpc = 32'h0;
    lat_mode = 0; data_xor = 1'b0; allow_stray = 1'b0;

    tick(); tick();
    #1;
    check_lit("reset_req", {31'd0, imem.imem_req}, 32'd1);
    check_lit("reset_addr", imem.imem_addr, 32'h0);
    check_lit("reset_valid", {31'd0, IF_ID_valid}, 32'd0);
    check_lit("reset_pp4", IF_ID_PC_Plus4, 32'h0);
    c_reset = 1'b0;

    // zero-wait, no stall, data = address
    tick(); #1;
    check_lit("zw_ins0", IF_ID_Instruction, 32'h0);
    check_lit("zw_pp4_0", IF_ID_PC_Plus4, 32'h4);
    check_lit("zw_valid0", {31'd0, IF_ID_valid}, 32'd1);
    tick(); #1;
    check_lit("zw_ins1", IF_ID_Instruction, 32'h4);
    check_lit("zw_pp4_1", IF_ID_PC_Plus4, 32'h8);
    tick(); #1;
    check_lit("zw_ins2", IF_ID_Instruction, 32'h8);
    repeat (4) tick();

    // two wait cycles per fetch
    lat_mode = 2;
    #1; a = imem.imem_addr;
    tick(); #1;
    check_lit("w2_addr_hold1", imem.imem_addr, a);
    check_lit("w2_valid1", {31'd0, IF_ID_valid}, 32'd0);
    tick(); #1;
    check_lit("w2_addr_hold2", imem.imem_addr, a);
    check_lit("w2_valid2", {31'd0, IF_ID_valid}, 32'd0);
    tick(); #1;
    check_lit("w2_valid3", {31'd0, IF_ID_valid}, 32'd1);
    check_lit("w2_ins3", IF_ID_Instruction, a);
    check_lit("w2_next_addr", imem.imem_addr, a + 32'd4);
    repeat (6) tick();

    // bubble while the response arrives
    lat_mode = 0;
    #1; a = imem.imem_addr; p = IF_ID_PC_Plus4; ins = IF_ID_Instruction;
    c_bubble = 1'b1;
    tick(); #1;
    check_lit("hold_req", {31'd0, imem.imem_req}, 32'd0);
    check_lit("hold_ins_kept", IF_ID_Instruction, ins);
    check_lit("hold_pp4_kept", IF_ID_PC_Plus4, p);
    tick(); tick(); #1;
    check_lit("hold_req3", {31'd0, imem.imem_req}, 32'd0);
    c_bubble = 1'b0;
    tick(); #1;
    check_lit("hold_release_ins", IF_ID_Instruction, a);
    check_lit("hold_release_pp4", IF_ID_PC_Plus4, a + 32'd4);
    check_lit("hold_release_addr", imem.imem_addr, a + 32'd4);

    // redirect during a wait: stale response is dropped
    lat_mode = 3;
    tick(); #1; a = imem.imem_addr;
    c_rv = 1'b1; c_rpc = 32'h0000_0103;
    tick(); #1; c_rv = 1'b0;
    check_lit("drop_addr_old", imem.imem_addr, a);
    check_lit("drop_req", {31'd0, imem.imem_req}, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(); #1;
      check_lit("drop_valid0", {31'd0, IF_ID_valid}, 32'd0);
      if (imem.imem_addr == 32'h0000_0100) found = 1'b1;
    end
    check_lit("drop_target_reached", {31'd0, found}, 32'd1);
    lat_mode = 0;
    tick(); #1;
    check_lit("drop_target_ins", IF_ID_Instruction, 32'h0000_0100);

    // redirect + bubble with ready; redirect during HOLD
    c_bubble = 1'b1; c_rv = 1'b1; c_rpc = 32'h0000_0200;
    tick(); #1;
    check_lit("rb_valid", {31'd0, IF_ID_valid}, 32'd0);
    check_lit("rb_addr", imem.imem_addr, 32'h0000_0200);
    c_rv = 1'b0;
    tick(); #1;
    check_lit("rb_hold_req", {31'd0, imem.imem_req}, 32'd0);
    c_rv = 1'b1; c_rpc = 32'h0000_0300;
    tick(); #1;
    check_lit("hr_addr", imem.imem_addr, 32'h0000_0300);
    check_lit("hr_req", {31'd0, imem.imem_req}, 32'd1);
    c_rv = 1'b0; c_bubble = 1'b0;
    tick(); #1;
    check_lit("hr_ins", IF_ID_Instruction, 32'h0000_0300);
    check_lit("hr_pp4", IF_ID_PC_Plus4, 32'h0000_0304);

    // PC wrap
    c_rv = 1'b1; c_rpc = 32'hFFFF_FFFC;
    tick(); c_rv = 1'b0;
    tick(); #1;
    check_lit("wrap_pp4", IF_ID_PC_Plus4, 32'h0);
    check_lit("wrap_ins", IF_ID_Instruction, 32'hFFFF_FFFC);
    check_lit("wrap_addr", imem.imem_addr, 32'h0);

    // reset in the middle of DROP
    lat_mode = 3;
    tick();
    c_rv = 1'b1; c_rpc = 32'h0000_0400;
    tick(); c_rv = 1'b0; c_reset = 1'b1;
    tick(); #1;
    check_lit("rst_drop_addr", imem.imem_addr, 32'h0);
    check_lit("rst_drop_req", {31'd0, imem.imem_req}, 32'd1);
    check_lit("rst_drop_valid", {31'd0, IF_ID_valid}, 32'd0);
    check_lit("rst_drop_ins", IF_ID_Instruction, 32'h0);
    c_reset = 1'b0;

    // random traffic
    lat_mode = -1; data_xor = 1'b1; allow_stray = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      c_bubble = ($urandom_range(0, 9) < 3);
      c_rv     = ($urandom_range(0, 9) == 0);
      c_rpc    = $urandom;
      c_reset  = ($urandom_range(0, 299) == 0);
      tick();
    end
    c_reset = 1'b0; c_rv = 1'b0; c_bubble = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage pipeline, directly upstream of ID. Owns the program counter, drives the instruction-memory request interface, and holds the IF/ID pipeline register (PC+4, instruction, valid) consumed by ID. Honours the hazard-detection `bubble` stall from ID and the branch/jump redirect from EX. Handles variable-latency memory with a one-entry hold buffer and a drop state for in-flight fetches made stale by a redirect.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value after reset; bits [1:0] must be 0.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `bubble`  in  1  stall from ID hazard detection; when high, hold PC and IF/ID.
- `redirect_valid`  in  1  branch taken or jump resolved in EX.
- `redirect_pc`  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; equals PC.
- `imem_ready`  in  1  response valid this cycle; completes the request.
- `imem_rdata`  in  32  instruction word, valid when `imem_ready`.
- `IF_ID_PC_Plus4`  out  32  registered PC+4 of the instruction held in IF/ID.
- `IF_ID_Instruction`  out  32  registered instruction; 32'h0 (NOP) when not valid.
- `IF_ID_valid`  out  1  IF/ID holds a real instruction.

## Operation
- Memory protocol: `imem_req`/`imem_addr` are held stable from assertion until the cycle `imem_ready`=1. A zero-wait memory asserts ready in the same cycle. Ready without req is ignored.
- FSM states: RUN, HOLD, DROP. `redirect_valid` has priority over `bubble` in every state.
- RUN (req=1):
  - redirect with ready: PC<=target, flush IF/ID, stay in RUN.
  - redirect without ready: store target in pending register, flush IF/ID, go to DROP.
  - ready with !bubble: IF/ID<={PC+4, rdata, 1}, PC<=PC+4.
  - ready with bubble: capture rdata in hold buffer, go to HOLD.
  - no ready: wait.
- HOLD (req=0):
  - redirect: discard hold buffer, PC<=target, flush, go to RUN.
  - !bubble: IF/ID<={PC+4, buffer, 1}, PC<=PC+4, go to RUN.
  - bubble: wait.
- DROP (req=1, addr=old PC):
  - IF_ID_valid held at 0.
  - a further redirect overwrites the pending target.
  - on ready: discard rdata, PC<=pending (or the new redirect target if one arrives the same cycle), go to RUN.
- Flush: valid<=0, Instruction<=0, PC_Plus4<=0.
- `bubble` alone: IF/ID and PC unchanged; an outstanding request continues.
- Arithmetic: 32-bit PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
- Reset: PC=RESET_PC, state=RUN, all IF/ID outputs 0, hold buffer and pending register 0. A reset during DROP or HOLD abandons all state. `imem_req` is 1 in the first cycle after reset.

## Timing
- Zero-wait memory, no stall: one instruction per cycle. The instruction at PC appears in IF/ID one edge after its request cycle.
- N wait cycles add N cycles of IF_ID_valid=0 (bubbles into ID).
- Redirect seen at edge k:
  - if ready that cycle, target is requested in cycle k+1.
  - otherwise, target is requested in the cycle after the stale response.
- `imem_req`, `imem_addr` and all IF_ID outputs are combinational only from state and PC; there is no input-to-output combinational path.

## Configuration
- `IF_PERF_CNT_EN` defined:
  - adds 32-bit wrapping counters `perf_fetched` (increments on each IF/ID load with valid=1) and `perf_stall` (increments each cycle `bubble`=1 or state≠RUN).
  - both counters are output ports and reset to 0.
- Not defined: counters and ports are absent; the rest of the behaviour is identical.

## Structure
- Package `if_pkg`: state enum (RUN, HOLD, DROP), `IF_NOP` = 32'h0, default `RESET_PC`.
- Sub-module `if_fetch_fsm`: state register, pending target and hold buffer; outputs next-PC select and IF/ID load/flush strobes. The top level holds PC, IF/ID and the perf counters.

## Test plan
- Reset then zero-wait memory returning addr as data, no stall → IF_ID_Instruction = 0, 4, 8… on consecutive cycles; IF_ID_PC_Plus4 = 4, 8, 12…
- Memory with 2 wait cycles → `imem_addr` stable for 3 cycles; IF_ID_valid pattern 1,0,0 repeating.
- `bubble`=1 for 3 cycles while ready arrives → state HOLD, req=0, IF/ID unchanged; on release, the buffered word loads next edge and PC advances by 4.
- Redirect to 32'h0000_0103 during a wait → addr stays at old PC until ready, stale data dropped, next request to 32'h0000_0100, IF_ID_valid=0 throughout.
- Redirect and `bubble` together in RUN with ready → flush wins, PC=target; also a redirect during HOLD discards the buffer.
- PC=32'hFFFF_FFFC fetch → IF_ID_PC_Plus4=0, next `imem_addr`=0; reset asserted mid-DROP → PC=RESET_PC and outputs 0 next edge.
